// File: rtl/neuron_layer_seq.sv
// Sequencer that time-shares one neuron_hidden datapath across the neurons of a hidden layer.
// It issues one weight-ROM row per cycle, tags each row as it goes in flight, and collects the activations into a packed bank.
module neuron_layer_seq #(
    parameter int N_NEURONS = 8,
    parameter int AW        = 3,
    parameter int ROM_LAT   = 1,
    parameter int PIPE_LAT  = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [135:0]             x_in,
    output logic                     busy,
    output logic                     done,
    output logic [AW-1:0]            w_addr,
    output logic                     w_rd,
    output logic                     nrn_ce,
    output logic [135:0]             nrn_x,
    input  logic [16:0]              nrn_y,
    output logic [17*N_NEURONS-1:0]  y_out,
    output logic                     y_valid
);

    localparam int              LAT       = ROM_LAT + PIPE_LAT;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(N_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                        state_q, state_d;
    logic [AW:0]                   tag_q [LAT];
    logic [N_NEURONS-1:0][16:0]    y_q;
    logic                          tail_valid;
    logic [AW-1:0]                 tail_idx;
    logic                          accept;
    logic                          last_capture;

    // Each tag is {valid, neuron index}. It reaches the tail in the same cycle as the result it describes.
    assign tail_valid   = tag_q[LAT-1][AW];
    assign tail_idx     = tag_q[LAT-1][AW-1:0];
    assign accept       = (state_q == IDLE) && start;
    assign last_capture = tail_valid && (tail_idx == LAST_ADDR);
    assign y_out        = y_q;

    // NOTE: every output and next-state term gets a default before the case, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        w_rd    = 1'b0;
        nrn_ce  = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                w_rd   = 1'b1;
                nrn_ce = 1'b1;
                if (w_addr == LAST_ADDR) state_d = DRAIN;
            end
            DRAIN: begin
                nrn_ce = 1'b1;
                if (last_capture) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments, so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_addr  <= '0;
            nrn_x   <= '0;
            y_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                nrn_x   <= x_in;
                y_valid <= 1'b0;
            end
            // The address holds at the last row while draining, so the compare can never wrap.
            if (state_q == ISSUE && w_addr != LAST_ADDR)
                w_addr <= w_addr + 1'b1;
            if (state_q == DONE) begin
                w_addr  <= '0;
                y_valid <= 1'b1;
            end
        end
    end

    // NOTE: the tag shift register and the y bank are reset on purpose. A reset in mid-pass must discard every result still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
            y_q <= '0;
        end else begin
            tag_q[0] <= {w_rd, w_addr};
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
            for (int k = 0; k < N_NEURONS; k++)
                if (tail_valid && tail_idx == AW'(k)) y_q[k] <= nrn_y;
        end
    end

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Bench for neuron_layer_seq: it models the weight ROM and the datapath with their latency.
// It checks the timing of each cycle of a pass and compares the bank contents with a plain-arithmetic activation model.
module tb_neuron_layer_seq;

    localparam int D_N   = 8;
    localparam int D_LAT = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // default instance
    logic           start_d = 1'b0;
    logic [135:0]   x_d = '0;
    logic           busy_d, done_d, w_rd_d, nrn_ce_d, y_valid_d;
    logic [2:0]     w_addr_d;
    logic [135:0]   nrn_x_d;
    logic [16:0]    nrn_y_d;
    logic [135:0]   y_out_d;

    // N_NEURONS=1 instance
    logic           start_1 = 1'b0;
    logic [135:0]   x_1 = '0;
    logic           busy_1, done_1, w_rd_1, nrn_ce_1, y_valid_1;
    logic [0:0]     w_addr_1;
    logic [135:0]   nrn_x_1;
    logic [16:0]    nrn_y_1;
    logic [16:0]    y_out_1;

    // N_NEURONS=5, PIPE_LAT=3 instance
    logic           start_5 = 1'b0;
    logic [135:0]   x_5 = '0;
    logic           busy_5, done_5, w_rd_5, nrn_ce_5, y_valid_5;
    logic [2:0]     w_addr_5;
    logic [135:0]   nrn_x_5;
    logic [16:0]    nrn_y_5;
    logic [84:0]    y_out_5;

    neuron_layer_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start_d), .x_in(x_d), .busy(busy_d), .done(done_d),
        .w_addr(w_addr_d), .w_rd(w_rd_d), .nrn_ce(nrn_ce_d), .nrn_x(nrn_x_d), .nrn_y(nrn_y_d),
        .y_out(y_out_d), .y_valid(y_valid_d)
    );

    neuron_layer_seq #(.N_NEURONS(1), .AW(1)) dut_1 (
        .clk(clk), .rst_n(rst_n), .start(start_1), .x_in(x_1), .busy(busy_1), .done(done_1),
        .w_addr(w_addr_1), .w_rd(w_rd_1), .nrn_ce(nrn_ce_1), .nrn_x(nrn_x_1), .nrn_y(nrn_y_1),
        .y_out(y_out_1), .y_valid(y_valid_1)
    );

    neuron_layer_seq #(.N_NEURONS(5), .AW(3), .PIPE_LAT(3)) dut_5 (
        .clk(clk), .rst_n(rst_n), .start(start_5), .x_in(x_5), .busy(busy_5), .done(done_5),
        .w_addr(w_addr_5), .w_rd(w_rd_5), .nrn_ce(nrn_ce_5), .nrn_x(nrn_x_5), .nrn_y(nrn_y_5),
        .y_out(y_out_5), .y_valid(y_valid_5)
    );

    // Stand-in for neuron_hidden: a Q.12 dot product, then a clamped linear sigmoid, 0.5 + s/4 limited to [0, 1].
    function automatic logic [16:0] ref_act(input logic [135:0] x, input logic [135:0] w);
        longint acc;
        acc = 0;
        for (int i = 0; i < 8; i++)
            acc += longint'($signed(x[17*i +: 17])) * longint'($signed(w[17*i +: 17]));
        acc = (acc >>> 14) + 2048;
        if (acc < 0)    acc = 0;
        if (acc > 4096) acc = 4096;
        return 17'(acc);
    endfunction

    function automatic logic [135:0] rand_vec();
        logic [135:0] v;
        for (int i = 0; i < 8; i++) v[17*i +: 17] = 17'($urandom_range(0, 4095)) - 17'd2048;
        return v;
    endfunction

    // Weight ROM shared by the three instances. Results come out LAT cycles after the row is issued, and idle slots carry random data.
    logic [135:0] rom [D_N];
    logic [6:0][16:0] pipe_d, pipe_1;
    logic [3:0][16:0] pipe_5;

    always @(posedge clk) begin
        pipe_d <= {pipe_d[5:0], w_rd_d ? ref_act(nrn_x_d, rom[w_addr_d]) : 17'($urandom)};
        pipe_1 <= {pipe_1[5:0], w_rd_1 ? ref_act(nrn_x_1, rom[{2'b00, w_addr_1}]) : 17'($urandom)};
        pipe_5 <= {pipe_5[2:0], w_rd_5 ? ref_act(nrn_x_5, rom[w_addr_5]) : 17'($urandom)};
    end
    assign nrn_y_d = pipe_d[6];
    assign nrn_y_1 = pipe_1[6];
    assign nrn_y_5 = pipe_5[3];

    // Expected contents of the default instance between passes
    logic [16:0]  y_bank [D_N];
    logic         bank_valid = 1'b0;
    logic [135:0] cur_x = '0;

    function automatic logic [135:0] bank_packed();
        logic [135:0] v;
        for (int k = 0; k < D_N; k++) v[17*k +: 17] = y_bank[k];
        return v;
    endfunction

    task automatic clear_bank();
        for (int k = 0; k < D_N; k++) y_bank[k] = '0;
        bank_valid = 1'b0;
        cur_x      = '0;
    endtask

    // One pass of the default instance. Cycle 0 is the start cycle, and the task stops after cycle stop_c.
    // With ign set, it also pulses start with x_alt in cycles 3 and 16.
    task automatic run_pass(input logic [135:0] x, input logic [135:0] x_alt, input bit ign, input int stop_c);
        logic [16:0]  tgt [D_N];
        logic [135:0] exp_y;
        logic [4:0]   exp_st, got_st;
        for (int k = 0; k < D_N; k++) tgt[k] = ref_act(x, rom[k]);
        for (int c = 0; c <= stop_c; c++) begin
            @(negedge clk);
            exp_st = {c >= 1, c == D_N + D_LAT + 1, c >= 1 && c <= D_N, c >= 1 && c <= D_N + D_LAT,
                      c == 0 ? bank_valid : 1'b0};
            got_st = {busy_d, done_d, w_rd_d, nrn_ce_d, y_valid_d};
            vecs++;
            if (got_st !== exp_st) begin
                errs++;
                $display("FAIL pass_ctrl cycle %0d: {busy,done,w_rd,ce,y_valid} got %b expected %b", c, got_st, exp_st);
            end
            if (c >= 1 && c <= D_N) begin
                vecs++;
                if (w_addr_d !== 3'(c - 1)) begin
                    errs++;
                    $display("FAIL w_addr cycle %0d: got %0d expected %0d", c, w_addr_d, c - 1);
                end
            end
            vecs++;
            if (nrn_x_d !== (c >= 1 ? x : cur_x)) begin
                errs++;
                $display("FAIL nrn_x cycle %0d: got %h expected %h", c, nrn_x_d, (c >= 1 ? x : cur_x));
            end
            for (int k = 0; k < D_N; k++)
                exp_y[17*k +: 17] = (c >= k + D_LAT + 2) ? tgt[k] : y_bank[k];
            vecs++;
            if (y_out_d !== exp_y) begin
                errs++;
                $display("FAIL y_out cycle %0d: got %h expected %h", c, y_out_d, exp_y);
            end
            start_d = (c == 0) || (ign && (c == 3 || c == D_N + D_LAT + 1));
            x_d     = (c == 0) ? x : x_alt;
        end
        if (stop_c >= D_N + D_LAT + 1) begin
            for (int k = 0; k < D_N; k++) y_bank[k] = tgt[k];
            bank_valid = 1'b1;
            cur_x      = x;
        end
    endtask

    task automatic idle_cycles(input int n);
        logic [4:0] got_st;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            got_st = {busy_d, done_d, w_rd_d, nrn_ce_d, y_valid_d};
            vecs++;
            if (got_st !== {4'b0000, bank_valid}) begin
                errs++;
                $display("FAIL idle_ctrl: got %b expected %b", got_st, {4'b0000, bank_valid});
            end
            vecs++;
            if (nrn_x_d !== cur_x || y_out_d !== bank_packed()) begin
                errs++;
                $display("FAIL idle_hold: nrn_x %h y_out %h expected %h / %h", nrn_x_d, y_out_d, cur_x, bank_packed());
            end
            start_d = 1'b0;
            x_d     = rand_vec();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vecs++;
        if ({busy_d, done_d, w_rd_d, nrn_ce_d, y_valid_d, w_addr_d} !== '0 || nrn_x_d !== '0 || y_out_d !== '0) begin
            errs++;
            $display("FAIL reset_default: ctrl %b%b%b%b%b addr %0d nrn_x %h y_out %h expected all zero",
                     busy_d, done_d, w_rd_d, nrn_ce_d, y_valid_d, w_addr_d, nrn_x_d, y_out_d);
        end
        vecs++;
        if ({busy_1, done_1, w_rd_1, nrn_ce_1, y_valid_1, w_addr_1, y_out_1} !== '0 ||
            {busy_5, done_5, w_rd_5, nrn_ce_5, y_valid_5, w_addr_5, y_out_5} !== '0) begin
            errs++;
            $display("FAIL reset_edge: got %h / %h expected 0",
                     {busy_1, done_1, w_rd_1, nrn_ce_1, y_valid_1, w_addr_1, y_out_1},
                     {busy_5, done_5, w_rd_5, nrn_ce_5, y_valid_5, w_addr_5, y_out_5});
        end
        rst_n = 1'b1;
        idle_cycles(20);
    endtask

    // Nominal pass, then a second pass with ignored starts, and a third pass that starts in the cycle right after done.
    task automatic test_nominal_ignore_b2b();
        for (int k = 0; k < D_N; k++) rom[k] = {8{17'(32'h1000 * (k + 1))}};
        run_pass({8{17'h01000}}, rand_vec(), 1'b0, D_N + D_LAT + 1);
        idle_cycles(2);
        for (int k = 0; k < D_N; k++) rom[k] = rand_vec();
        run_pass(rand_vec(), rand_vec(), 1'b1, D_N + D_LAT + 1);
        for (int k = 0; k < D_N; k++) rom[k] = rand_vec();
        run_pass(rand_vec(), rand_vec(), 1'b0, D_N + D_LAT + 1);
        idle_cycles(5);
    endtask

    task automatic test_reset_mid_pass();
        for (int k = 0; k < D_N; k++) rom[k] = rand_vec();
        run_pass(rand_vec(), rand_vec(), 1'b0, 8);
        @(negedge clk);
        rst_n   = 1'b0;
        start_d = 1'b0;
        @(negedge clk);
        vecs++;
        if ({busy_d, done_d, w_rd_d, nrn_ce_d, y_valid_d, w_addr_d} !== '0 || nrn_x_d !== '0 || y_out_d !== '0) begin
            errs++;
            $display("FAIL mid_reset: ctrl %b%b%b%b%b addr %0d y_out %h expected all zero",
                     busy_d, done_d, w_rd_d, nrn_ce_d, y_valid_d, w_addr_d, y_out_d);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_bank();
        idle_cycles(12);
        for (int k = 0; k < D_N; k++) rom[k] = rand_vec();
        run_pass(rand_vec(), rand_vec(), 1'b0, D_N + D_LAT + 1);
        idle_cycles(2);
    endtask

    task automatic test_random_passes();
        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < D_N; k++) rom[k] = rand_vec();
            run_pass(rand_vec(), rand_vec(), 1'($urandom_range(0, 1)), D_N + D_LAT + 1);
            idle_cycles(int'($urandom_range(0, 3)));
        end
    endtask

    // N_NEURONS=1 (LAT 7) must finish in cycle 9; N_NEURONS=5 with PIPE_LAT=3 (LAT 4) must finish in cycle 10.
    task automatic test_edge_params();
        logic [135:0] x;
        logic [84:0]  exp5;
        logic [5:0]   got_st, exp_st;
        x = rand_vec();
        for (int k = 0; k < D_N; k++) rom[k] = rand_vec();
        for (int k = 0; k < 5; k++) exp5[17*k +: 17] = ref_act(x, rom[k]);
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            got_st = {busy_1, done_1, w_rd_1, busy_5, done_5, w_rd_5};
            exp_st = {c >= 1 && c <= 9, c == 9, c == 1, c >= 1 && c <= 10, c == 10, c >= 1 && c <= 5};
            vecs++;
            if (got_st !== exp_st) begin
                errs++;
                $display("FAIL edge_ctrl cycle %0d: {busy1,done1,rd1,busy5,done5,rd5} got %b expected %b", c, got_st, exp_st);
            end
            vecs++;
            if ({nrn_ce_1, nrn_ce_5} !== {c >= 1 && c <= 8, c >= 1 && c <= 9}) begin
                errs++;
                $display("FAIL edge_ce cycle %0d: got %b expected %b", c, {nrn_ce_1, nrn_ce_5},
                         {c >= 1 && c <= 8, c >= 1 && c <= 9});
            end
            if (c >= 1 && c <= 5) begin
                vecs++;
                if (w_addr_5 !== 3'(c - 1)) begin
                    errs++;
                    $display("FAIL edge_addr5 cycle %0d: got %0d expected %0d", c, w_addr_5, c - 1);
                end
            end
            if (c == 10) begin
                vecs++;
                if (y_valid_1 !== 1'b1 || y_out_1 !== ref_act(x, rom[0])) begin
                    errs++;
                    $display("FAIL edge_y1: valid %b y %h expected 1 / %h", y_valid_1, y_out_1, ref_act(x, rom[0]));
                end
            end
            if (c == 11) begin
                vecs++;
                if (y_valid_5 !== 1'b1 || y_out_5 !== exp5) begin
                    errs++;
                    $display("FAIL edge_y5: valid %b y %h expected 1 / %h", y_valid_5, y_out_5, exp5);
                end
            end
            start_1 = (c == 0);
            start_5 = (c == 0);
            x_1     = (c == 0) ? x : rand_vec();
            x_5     = (c == 0) ? x : rand_vec();
        end
    endtask

    initial begin
        clear_bank();
        for (int k = 0; k < D_N; k++) rom[k] = '0;
        test_reset();
        test_nominal_ignore_b2b();
        test_reset_mid_pass();
        test_random_passes();
        test_edge_params();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
